gpio_port: RTL and testbench
============================

GPIO_PORT -- requirements
Module: gpio_port

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of pins (legal range 1..16).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, input synchroniser depth (legal range 2..4).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port cs  input  1  chip select.
REQ-006 SHALL have port wr  input  1  write strobe (1 = write, qualified by cs).
REQ-007 SHALL have port addr  input  32  byte address; only addr[4:2] decoded.
REQ-008 SHALL have port wdata  input  32  write data.
REQ-009 SHALL have port rdata  output  32  read data, combinational from addr.
REQ-010 SHALL have port ioport  inout  WIDTH  bidirectional pins.
REQ-011 SHALL have port irq  output  1  level interrupt request.

Function
REQ-012 SHALL map registers by addr[4:2]: 0 MODER, 1 IDR, 2 ODR, 3 BSRR, 4 IER, 5 RISE, 6 FALL, 7 ISR.
REQ-013 SHALL implement registers as WIDTH bits; unused upper bits read 0 and ignore writes.
REQ-014 SHALL write MODER, ODR, IER, RISE, FALL from wdata[WIDTH-1:0] on a cycle with cs=1, wr=1 and a matching address.
REQ-015 SHALL treat IDR as read-only; writes to it have no effect.
REQ-016 SHALL treat BSRR as write-only: wdata[i] sets ODR[i], wdata[16+i] clears ODR[i]; if both are set, the set wins; reads return 0.
REQ-017 SHALL clear ISR bit i on a write with wdata[i]=1 (W1C); bits written 0 are unchanged.
REQ-018 SHALL drive ioport[i] = ODR[i] when MODER[i]=1, else high-Z.
REQ-019 SHALL pass each ioport bit through a SYNC_STAGES-flop synchroniser, then register the result into IDR every cycle for all pins, including pins in output mode.
REQ-020 SHALL define a rising edge on pin i as sync_out[i]=1 and IDR[i]=0, and a falling edge as the reverse, evaluated only when MODER[i]=0.
REQ-021 SHALL set ISR[i] on the same clock edge that IDR[i] updates when (rise and RISE[i]) or (fall and FALL[i]).
REQ-022 SHALL give an edge set priority over a simultaneous W1C clear of the same ISR bit.
REQ-023 SHALL set ISR regardless of IER; drive irq = OR of (ISR & IER), combinational.
REQ-024 SHALL NOT set ISR on a MODER change by itself; switching a pin from output to input creates an edge only if the sync output then differs from IDR.
REQ-025 SHALL make a pad change stable before edge k visible in IDR and ISR after edge k+SYNC_STAGES (latency SYNC_STAGES+1 edges).
REQ-026 SHALL ignore writes when cs=0 or wr=0; reads have no side effects.

Reset
REQ-027 SHALL, while reset_n=0, asynchronously clear MODER, ODR, IDR, IER, RISE, FALL, ISR and all synchroniser flops to 0.
REQ-028 SHALL, at reset, hold all ioport pins high-Z, irq=0, and rdata equal to the addressed register (0).
REQ-029 SHALL NOT generate ISR events from reset release itself, because IDR and the synchroniser both start at 0; a pad held high yields one rising edge after release if RISE is enabled.

Configuration
REQ-030 SHALL provide interrupt logic (REQ-017, REQ-020..REQ-024, IER/RISE/FALL/ISR) only when macro GPIO_PORT_IRQ_EN is defined.
REQ-031 SHALL, without GPIO_PORT_IRQ_EN, read addresses 4..7 as 0, ignore writes to them, tie irq to 0, and retain MODER/IDR/ODR/BSRR behaviour unchanged.

Verification
REQ-032 SHALL cover: write MODER=0x0F, ODR=0xA5 -> ioport[3:0]=4'h5 driven, ioport[7:4]=Z, rdata@0x8=0xA5.
REQ-033 SHALL cover: ODR=0x0F, write BSRR=0x0001_0030 -> ODR=0x3E; BSRR=0x0001_0001 -> bit0 stays 1; read BSRR -> 0.
REQ-034 SHALL cover: MODER=0, drive ioport[2] 0->1 before edge k -> IDR[2]=1 after edge k+2 (SYNC_STAGES=2), not after edge k+1.
REQ-035 SHALL cover: RISE=0x04, IER=0x04, rising edge on pin2 -> ISR=0x04, irq=1; write ISR=0x04 -> ISR=0, irq=0; falling edge -> no set.
REQ-036 SHALL cover: W1C of ISR[2] on the same cycle as a new pin2 edge -> ISR[2] stays 1; IER=0 -> ISR sets but irq=0.
REQ-037 SHALL cover: assert reset_n=0 mid-operation with MODER=0xFF, ISR=0x10 -> all outputs Z, irq=0, and all registers 0 immediately without a clock edge.

Source files
------------

// File: rtl/gpio_port_if.sv
// gpio_port_if: register bus for gpio_port (cs, wr, addr, wdata from master; rdata from slave).
interface gpio_port_if;
  logic        cs;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  modport master(output cs, wr, addr, wdata, input rdata);
  modport slave(input cs, wr, addr, wdata, output rdata);
endinterface

// File: rtl/gpio_port.sv
// gpio_port: WIDTH-pin GPIO; ports clk, reset_n (async low), bus (cs/wr/addr/wdata/rdata), ioport (pins), irq; edge interrupts only with GPIO_PORT_IRQ_EN.
module gpio_port #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  gpio_port_if.slave       bus,
  inout  wire  [WIDTH-1:0] ioport,
  output logic             irq
);
  logic [2:0] sel;
  logic we;
  logic unused_bits;
  logic [WIDTH-1:0] moder_q, moder_d, odr_q, odr_d, idr_q, idr_d, sync_out;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  assign sel = bus.addr[4:2];
  assign we = bus.cs & bus.wr;
  assign sync_out = sync_q[SYNC_STAGES-1];
  assign unused_bits = ^{bus.addr, bus.wdata};
  for (genvar i = 0; i < WIDTH; i++) begin : g_pad
    assign ioport[i] = moder_q[i] ? odr_q[i] : 1'bz;
  end
  // Stage 0 samples the pads; the last stage feeds IDR, so IDR lags the pad by SYNC_STAGES+1 edges.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], ioport};
    idr_d = sync_out;
    moder_d = (we && sel == 3'd0) ? bus.wdata[WIDTH-1:0] : moder_q;
    // BSRR: clear first, then set, so a set on the same bit wins.
    odr_d = (we && sel == 3'd2) ? bus.wdata[WIDTH-1:0] :
            (we && sel == 3'd3) ? (odr_q & ~bus.wdata[16 +: WIDTH]) | bus.wdata[WIDTH-1:0] : odr_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync_q <= '0;
      idr_q <= '0;
      moder_q <= '0;
      odr_q <= '0;
    end else begin
      sync_q <= sync_d;
      idr_q <= idr_d;
      moder_q <= moder_d;
      odr_q <= odr_d;
    end
`ifdef GPIO_PORT_IRQ_EN
  logic [WIDTH-1:0] ier_q, ier_d, rise_q, rise_d, fall_q, fall_d, isr_q, isr_d, rise_ev, fall_ev;
  // Edges compare the synchroniser output against IDR, so they coincide with the IDR update.
  always_comb begin
    rise_ev = sync_out & ~idr_q & ~moder_q;
    fall_ev = ~sync_out & idr_q & ~moder_q;
    ier_d = (we && sel == 3'd4) ? bus.wdata[WIDTH-1:0] : ier_q;
    rise_d = (we && sel == 3'd5) ? bus.wdata[WIDTH-1:0] : rise_q;
    fall_d = (we && sel == 3'd6) ? bus.wdata[WIDTH-1:0] : fall_q;
    // New events are OR'd after the W1C clear so they win over it.
    isr_d = (isr_q & ~((we && sel == 3'd7) ? bus.wdata[WIDTH-1:0] : '0)) |
            (rise_ev & rise_q) | (fall_ev & fall_q);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ier_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
      isr_q <= '0;
    end else begin
      ier_q <= ier_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      isr_q <= isr_d;
    end
  assign irq = |(isr_q & ier_q);
  assign bus.rdata = sel == 3'd0 ? 32'(moder_q) :
                     sel == 3'd1 ? 32'(idr_q) :
                     sel == 3'd2 ? 32'(odr_q) :
                     sel == 3'd4 ? 32'(ier_q) :
                     sel == 3'd5 ? 32'(rise_q) :
                     sel == 3'd6 ? 32'(fall_q) :
                     sel == 3'd7 ? 32'(isr_q) : 32'd0;
`else
  assign irq = 1'b0;
  assign bus.rdata = sel == 3'd0 ? 32'(moder_q) :
                     sel == 3'd1 ? 32'(idr_q) :
                     sel == 3'd2 ? 32'(odr_q) : 32'd0;
`endif
endmodule

// File: tb/tb_gpio_port.sv
// tb_gpio_port: table-driven register checks plus hand sequences for sync latency, interrupts and async reset.
module tb_gpio_port;
  localparam int W = 8;
`ifdef GPIO_PORT_IRQ_EN
  localparam logic [31:0] IER_RB = 32'hFF;
`else
  localparam logic [31:0] IER_RB = 32'h0;
`endif
  typedef struct {
    logic        cs;
    logic        wr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] rexp;
  } vec_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [W-1:0] pad_en = '1;
  logic [W-1:0] pad_val = '0;
  wire  [W-1:0] ioport;
  logic irq;
  int total = 0;
  int bad = 0;
  vec_t vecs[15];
  gpio_port_if bus();
  gpio_port #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .ioport(ioport), .irq(irq)
  );
  always #10 clk = ~clk;
  for (genvar g = 0; g < W; g++) begin : g_drv
    assign ioport[g] = pad_en[g] ? pad_val[g] : 1'bz;
  end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  // Pins selected by m must be undriven (z in 4-state, 0 in 2-state).
  task automatic zchk(input string nm, input logic [W-1:0] got, input logic [W-1:0] m);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < W; i++)
      if (m[i] && got[i] !== 1'bz && got[i] !== 1'b0) ok = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s got=%b exp=z on mask %b", nm, got, m);
    end
  endtask
  task automatic cycle(input logic c, input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.cs = c;
    bus.wr = w;
    bus.addr = a;
    bus.wdata = d;
    @(posedge clk);
    #1;
    bus.cs = 1'b0;
    bus.wr = 1'b0;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cycle(1'b1, 1'b1, a, d);
  endtask
  task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
    bus.addr = a;
    #1;
    chk(nm, bus.rdata, exp);
  endtask
  initial begin
    bus.cs = 1'b0;
    bus.wr = 1'b0;
    bus.addr = '0;
    bus.wdata = '0;
    vecs[0]  = '{1'b1, 1'b1, 32'h00, 32'hFFFF_FF0F, 32'h00, 32'h0F};
    vecs[1]  = '{1'b1, 1'b1, 32'h08, 32'h0000_00A5, 32'h08, 32'hA5};
    vecs[2]  = '{1'b1, 1'b1, 32'h04, 32'h0000_00FF, 32'h04, 32'h35};
    vecs[3]  = '{1'b1, 1'b1, 32'h08, 32'h0000_000F, 32'h08, 32'h0F};
    vecs[4]  = '{1'b1, 1'b1, 32'h0C, 32'h0001_0030, 32'h08, 32'h3E};
    vecs[5]  = '{1'b1, 1'b1, 32'h0C, 32'h0001_0001, 32'h08, 32'h3F};
    vecs[6]  = '{1'b0, 1'b0, 32'h00, 32'h0000_0000, 32'h0C, 32'h00};
    vecs[7]  = '{1'b0, 1'b1, 32'h08, 32'h0000_0000, 32'h08, 32'h3F};
    vecs[8]  = '{1'b1, 1'b0, 32'h08, 32'h0000_0000, 32'h08, 32'h3F};
    vecs[9]  = '{1'b1, 1'b1, 32'h10, 32'h0000_00FF, 32'h10, IER_RB};
    vecs[10] = '{1'b1, 1'b1, 32'h10, 32'h0000_0000, 32'h10, 32'h00};
    vecs[11] = '{1'b0, 1'b0, 32'h00, 32'h0000_0000, 32'h1C, 32'h00};
    vecs[12] = '{1'b1, 1'b1, 32'hFFFF_FFE8, 32'h0000_00A5, 32'h08, 32'hA5};
    vecs[13] = '{1'b0, 1'b0, 32'h00, 32'h0000_0000, 32'h04, 32'h35};
    vecs[14] = '{1'b1, 1'b1, 32'h14, 32'h0000_0000, 32'hFFFF_FFE8, 32'hA5};
    #15;
    rd_chk("rst_moder", 32'h00, 32'h0);
    rd_chk("rst_odr", 32'h08, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    pad_en = 8'hF0;
    pad_val = 8'h30;
    for (int i = 0; i < 15; i++) begin
      cycle(vecs[i].cs, vecs[i].wr, vecs[i].waddr, vecs[i].wdata);
      repeat (3) @(posedge clk);
      #1;
      rd_chk($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].rexp);
    end
    chk("drive_lo", 32'(ioport[3:0]), 32'h5);
    pad_en = 8'h00;
    #1;
    zchk("z_hi", ioport, 8'hF0);
    pad_en = 8'hF0;
    wr(32'h00, 32'h0);
    pad_en = 8'hFF;
    pad_val = 8'h00;
    repeat (5) @(posedge clk);
    #1;
    rd_chk("idr_zero", 32'h04, 32'h0);
    @(negedge clk);
    pad_val[2] = 1'b1;
    @(posedge clk);
    #1 chk("lat_k", bus.rdata, 32'h0);
    @(posedge clk);
    #1 chk("lat_k1", bus.rdata, 32'h0);
    @(posedge clk);
    #1 chk("lat_k2", bus.rdata, 32'h04);
    rd_chk("isr_norise", 32'h1C, 32'h0);
`ifdef GPIO_PORT_IRQ_EN
    wr(32'h14, 32'h04);
    wr(32'h10, 32'h04);
    @(negedge clk) pad_val[2] = 1'b0;
    repeat (4) @(posedge clk);
    #1 rd_chk("fall_noset", 32'h1C, 32'h0);
    @(negedge clk) pad_val[2] = 1'b1;
    repeat (4) @(posedge clk);
    #1 rd_chk("rise_set", 32'h1C, 32'h04);
    chk("irq_on", 32'(irq), 32'h1);
    wr(32'h1C, 32'h04);
    rd_chk("w1c_clr", 32'h1C, 32'h0);
    chk("irq_off", 32'(irq), 32'h0);
    @(negedge clk) pad_val[2] = 1'b0;
    repeat (4) @(posedge clk);
    #1 rd_chk("fall2_noset", 32'h1C, 32'h0);
    @(negedge clk) pad_val[2] = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk) pad_val[2] = 1'b0;
    repeat (4) @(posedge clk);
    #1 rd_chk("pre_race", 32'h1C, 32'h04);
    @(negedge clk) pad_val[2] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    wr(32'h1C, 32'h04);
    rd_chk("race_set_wins", 32'h1C, 32'h04);
    wr(32'h10, 32'h0);
    wr(32'h1C, 32'h04);
    rd_chk("clr_again", 32'h1C, 32'h0);
    @(negedge clk) pad_val[2] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) pad_val[2] = 1'b1;
    repeat (4) @(posedge clk);
    #1 rd_chk("ier0_set", 32'h1C, 32'h04);
    chk("ier0_irq", 32'(irq), 32'h0);
    wr(32'h1C, 32'hFF);
    wr(32'h14, 32'h10);
    @(negedge clk) pad_val[4] = 1'b1;
    repeat (4) @(posedge clk);
    #1 rd_chk("isr_pin4", 32'h1C, 32'h10);
`else
    wr(32'h1C, 32'hFF);
    rd_chk("isr_absent", 32'h1C, 32'h0);
    chk("irq_tied", 32'(irq), 32'h0);
`endif
    pad_en = 8'h00;
    wr(32'h00, 32'hFF);
    wr(32'h08, 32'hFF);
    chk("drive_all", 32'(ioport), 32'hFF);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    zchk("rst_z", ioport, 8'hFF);
    chk("rst_irq_async", 32'(irq), 32'h0);
    rd_chk("rst_moder_async", 32'h00, 32'h0);
    rd_chk("rst_odr_async", 32'h08, 32'h0);
    rd_chk("rst_idr_async", 32'h04, 32'h0);
    rd_chk("rst_rise_async", 32'h14, 32'h0);
    rd_chk("rst_isr_async", 32'h1C, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
